// File: rtl/wam_pkg.sv
// Shared constants and the digit-to-segment decode used by the keypad scanner
// and the score displays.
package wam_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam int         N_ROWS    = 3;
  localparam int         N_COLS    = 3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments packed as {g,f,e,d,c,b,a}
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_tick_divider.sv
// Free-running wrap-around counter producing a one-clock tick at the
// terminal count.
module scan_tick_divider (
  input  logic        clk,
  input  logic        clear,
  input  logic [27:0] counter_max,
  input  logic        enable,
  output logic [27:0] counter,
  output logic        tick
);

  assign tick = enable && (counter == counter_max);

  always_ff @(posedge clk) begin
    if (!clear) begin
      counter <= '0;
    end else if (enable) begin
      counter <= (counter == counter_max) ? '0 : counter + 28'd1;
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// 3x3 key matrix scanner: column drive, per-frame lowest-key capture,
// frame-based debounce and a registered 7-segment image of the held key.
//
// state        | meaning
// ST_RELEASED  | no key accepted as held; waiting for a stable non-empty frame
// ST_HELD      | key accepted; waiting for a stable empty frame
module keypad_scan_controller
  import wam_pkg::*;
#(
  parameter int SCAN_DIV = 49_999,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] row,
  output logic [2:0] column,
  output logic [3:0] key,
  output logic       valid_key,
  output logic       key_down,
  output logic [6:0] hex
);

  localparam int              CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE);

  typedef enum logic {ST_RELEASED, ST_HELD} state_t;

  state_t           state;
  logic             tick;
  logic [27:0]      div_count_unused;
  logic [1:0]       col_idx;
  logic [3:0]       cand;
  logic [3:0]       frame_res;
  logic [3:0]       frame_final;
  logic [3:0]       prev_res;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_end;
  logic             stable;
  logic             press;
  logic             release_ok;

  scan_tick_divider u_div (
    .clk         (clk),
    .clear       (clear),
    .counter_max (28'(SCAN_DIV)),
    .enable      (1'b1),
    .counter     (div_count_unused),
    .tick        (tick)
  );

  always_comb begin
    case (column)
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  // Walk rows high to low so the lowest closed row wins
  always_comb begin
    cand = KEY_NONE;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (row[r]) cand = 4'(r * N_COLS) + {2'b00, col_idx};
    end
  end

  always_comb begin
    frame_end   = tick && column[2];
    frame_final = (frame_res != KEY_NONE) ? frame_res : cand;
    if (frame_final == prev_res) begin
      cnt_next = (stable_cnt == DB_MAX) ? DB_MAX : stable_cnt + CNT_W'(1);
    end else begin
      cnt_next = CNT_W'(1);
    end
    stable     = (cnt_next == DB_MAX);
    press      = frame_end && stable && (frame_final != KEY_NONE) && (state == ST_RELEASED);
    release_ok = frame_end && stable && (frame_final == KEY_NONE) && (state == ST_HELD);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state      <= ST_RELEASED;
      column     <= 3'b001;
      key        <= KEY_NONE;
      valid_key  <= 1'b0;
      key_down   <= 1'b0;
      hex        <= SEG_BLANK;
      frame_res  <= KEY_NONE;
      prev_res   <= KEY_NONE;
      stable_cnt <= '0;
    end else begin
      valid_key <= 1'b0;
      if (tick) begin
        column <= {column[1:0], column[2]};
        if (frame_end) begin
          frame_res  <= KEY_NONE;
          prev_res   <= frame_final;
          stable_cnt <= cnt_next;
        end else if (frame_res == KEY_NONE) begin
          frame_res <= cand;
        end
      end
      case (state)
        ST_RELEASED: begin
          if (press) begin
            state     <= ST_HELD;
            key       <= frame_final;
            key_down  <= 1'b1;
            valid_key <= 1'b1;
            hex       <= (frame_final <= 4'd8) ? digit_to_seg(frame_final) : SEG_BLANK;
          end
        end
        ST_HELD: begin
          if (release_ok) begin
            state    <= ST_RELEASED;
            key_down <= 1'b0;
            hex      <= SEG_BLANK;
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: matrix emulation, frame-history model and
// directed key scenarios.
module tb_keypad_scan_controller;

  localparam int SD = 3;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] row;
  logic [2:0] column;
  logic [3:0] key;
  logic       valid_key;
  logic       key_down;
  logic [6:0] hex;
  logic [8:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_controller #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .clear     (clear),
    .row       (row),
    .column    (column),
    .key       (key),
    .valid_key (valid_key),
    .key_down  (key_down),
    .hex       (hex)
  );

  // Key matrix: a closed key connects its driven column to its row
  always_comb begin
    row = '0;
    for (int c = 0; c < 3; c++) begin
      if (column[c]) begin
        for (int r = 0; r < 3; r++) begin
          if (pressed[r*3+c]) row[r] = 1'b1;
        end
      end
    end
  end

  // Model: ticks every SD+1 clocks after reset, columns in turn, frame = 3 ticks,
  // accept when the last DB frame results are identical.
  logic [6:0] seg_tab [9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  int  cyc;
  int  m_key;
  bit  m_down;
  bit  m_valid;
  int  frame_acc;
  int  hist[$];
  int  mc;
  bit  m_stable;

  always @(posedge clk) begin
    if (!clear) begin
      cyc = 0; m_key = 15; m_down = 0; m_valid = 0; frame_acc = 15;
      hist.delete();
    end else begin
      m_valid = 0;
      if (cyc % (SD + 1) == SD) begin
        mc = (cyc / (SD + 1)) % 3;
        for (int r = 0; r < 3; r++) begin
          if (frame_acc == 15 && pressed[r*3+mc]) frame_acc = r * 3 + mc;
        end
        if (mc == 2) begin
          hist.push_back(frame_acc);
          if (hist.size() > DB) void'(hist.pop_front());
          m_stable = (hist.size() == DB);
          foreach (hist[i]) if (hist[i] != frame_acc) m_stable = 0;
          if (m_stable && frame_acc != 15 && !m_down) begin
            m_key = frame_acc; m_down = 1; m_valid = 1;
          end else if (m_stable && frame_acc == 15) begin
            m_down = 0;
          end
          frame_acc = 15;
        end
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_column", 32'(column), 32'(3'b001 << ((cyc / (SD + 1)) % 3)));
      chk("m_key", 32'(key), 32'(m_key));
      chk("m_key_down", 32'(key_down), 32'(m_down));
      chk("m_valid_key", 32'(valid_key), 32'(m_valid));
      chk("m_hex", 32'(hex), m_down ? 32'(seg_tab[m_key]) : 32'h7F);
      if (valid_key === 1'b1) pulses++;
    end
  end

  task automatic wait_valid(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (valid_key === 1'b1) got = 1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_column"}, 32'(column), 32'h1);
    chk({tag, "_key"}, 32'(key), 32'hF);
    chk({tag, "_key_down"}, 32'(key_down), 32'h0);
    chk({tag, "_valid"}, 32'(valid_key), 32'h0);
    chk({tag, "_hex"}, 32'(hex), 32'h7F);
  endtask

  logic [2:0] col_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    bit got;
    int p0;
    clear = 1'b0;
    pressed = '0;
    @(posedge clk);
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    clear = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("col_rotate", 32'(column), 32'(col_seq[i]));
      repeat (4) @(negedge clk);
    end

    // key 4: row 1, column 1
    p0 = pulses;
    pressed = 9'h010;
    wait_valid(36, got);
    chk("press4_in_time", 32'(got), 32'h1);
    chk("press4_key", 32'(key), 32'h4);
    chk("press4_down", 32'(key_down), 32'h1);
    chk("press4_hex", 32'(hex), 32'h19);
    repeat (30) @(negedge clk);
    chk("press4_one_pulse", 32'(pulses - p0), 32'h1);

    pressed = '0;
    repeat (36) @(negedge clk);
    chk("rel4_down", 32'(key_down), 32'h0);
    chk("rel4_key_kept", 32'(key), 32'h4);
    chk("rel4_hex", 32'(hex), 32'h7F);
    chk("rel4_no_pulse", 32'(pulses - p0), 32'h1);

    clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset2");
    clear = 1'b1;

    p0 = pulses;
    pressed = 9'h004;
    repeat (12) @(negedge clk);
    pressed = '0;
    repeat (36) @(negedge clk);
    chk("bounce_no_pulse", 32'(pulses - p0), 32'h0);
    chk("bounce_key", 32'(key), 32'hF);
    chk("bounce_down", 32'(key_down), 32'h0);

    p0 = pulses;
    pressed = 9'h088;
    wait_valid(36, got);
    chk("dual_in_time", 32'(got), 32'h1);
    chk("dual_key", 32'(key), 32'h3);
    chk("dual_hex", 32'(hex), 32'h30);
    repeat (30) @(negedge clk);
    chk("dual_one_pulse", 32'(pulses - p0), 32'h1);
    pressed = '0;
    repeat (36) @(negedge clk);

    pressed = 9'h100;
    wait_valid(36, got);
    chk("press8_in_time", 32'(got), 32'h1);
    chk("press8_key", 32'(key), 32'h8);
    repeat (5) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk_reset_vals("midhold_reset");
    clear = 1'b1;
    p0 = pulses;
    wait_valid(36, got);
    chk("repress8_in_time", 32'(got), 32'h1);
    chk("repress8_key", 32'(key), 32'h8);
    chk("repress8_hex", 32'(hex), 32'h00);
    repeat (4) @(negedge clk);
    chk("repress8_one_pulse", 32'(pulses - p0), 32'h1);
    pressed = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
